dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one synchronous-read data memory port between the CPU M-stage and a DMA engine.
// Build option DM_ARB_ROUND_ROBIN_EN selects round-robin contention; default is fixed CPU priority.
module dm_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_byteen,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata
);

  // state | meaning
  // IDLE  | no access in flight; arbitrate pending requests
  // ADDR  | address phase: mem_en with latched owner fields; writes complete here
  // DATA  | read data phase: mem_rdata returned to owner; reads complete here
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  state_t      state;
  state_t      state_nxt;
  owner_t      owner;
  owner_t      winner;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  byteen_q;
  logic [31:0] cpu_rdata_q;
  logic [31:0] dma_rdata_q;
  logic        any_req;
  logic        is_write;
  logic        complete;
  logic        cpu_done;

  assign any_req  = cpu_req | dma_req;
  assign is_write = |byteen_q;

`ifdef DM_ARB_ROUND_ROBIN_EN
  owner_t last_served;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_served <= OWN_DMA;
    end else if (complete) begin
      last_served <= owner;
    end
  end

  // on contention the requester that was not served last wins
  always_comb begin
    winner = OWN_CPU;
    if (dma_req && (!cpu_req || last_served == OWN_CPU)) begin
      winner = OWN_DMA;
    end
  end
`else
  always_comb begin
    winner = OWN_CPU;
    if (dma_req && !cpu_req) begin
      winner = OWN_DMA;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ADDR;
      ADDR:    state_nxt = is_write ? IDLE : DATA;
      DATA:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // owner and its access fields are frozen for the whole access, so a dropped request cannot disturb it
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner    <= OWN_CPU;
      addr_q   <= '0;
      wdata_q  <= '0;
      byteen_q <= '0;
    end else if (state == IDLE && any_req) begin
      owner <= winner;
      if (winner == OWN_DMA) begin
        addr_q   <= dma_addr;
        wdata_q  <= dma_wdata;
        byteen_q <= dma_byteen;
      end else begin
        addr_q   <= cpu_addr;
        wdata_q  <= cpu_wdata;
        byteen_q <= cpu_byteen;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else if (state == DATA) begin
      if (owner == OWN_CPU) begin
        cpu_rdata_q <= mem_rdata;
      end else begin
        dma_rdata_q <= mem_rdata;
      end
    end
  end

  // reset gates every strobe so an aborted access never completes
  always_comb begin
    mem_en     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_byteen = '0;
    complete   = 1'b0;
    if (reset) begin
      case (state)
        ADDR: begin
          mem_en     = 1'b1;
          mem_addr   = addr_q & 32'hFFFF_FFFC;
          mem_wdata  = wdata_q;
          mem_byteen = byteen_q;
          complete   = is_write;
        end
        DATA:    complete = 1'b1;
        default: complete = 1'b0;
      endcase
    end
    cpu_done  = complete && (owner == OWN_CPU);
    dma_done  = complete && (owner == OWN_DMA);
    cpu_stall = cpu_req && !cpu_done;
    // read data is forwarded in the completion cycle, then held by the register
    cpu_rdata = (cpu_done && state == DATA) ? mem_rdata : cpu_rdata_q;
    dma_rdata = (dma_done && state == DATA) ? mem_rdata : dma_rdata_q;
  end

endmodule
